// File: rtl/hazard_unit.sv
// Stall/forwarding controller for the five-stage MIPS pipeline (Tuse/Tnew scheme).
// Define HAZARD_FWD_EN to enable forwarding; without it every RAW hazard stalls until the GRF holds the value.
module hazard_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [4:0] D_A3,
  input  logic       D_WDsel,
  input  logic [1:0] E_WDSel,
  input  logic       M_WDSel,
  input  logic       D_rs_Tuse,
  input  logic       D_rt_Tuse,
  input  logic       E_rs_Tuse,
  input  logic       E_rt_Tuse,
  input  logic       M_rt_Tuse,
  output logic       stall,
  output logic       PC_en,
  output logic       D_en,
  output logic       E_clr,
  output logic [1:0] D_fwd_rs,
  output logic [1:0] D_fwd_rt,
  output logic [1:0] E_fwd_rs,
  output logic [1:0] E_fwd_rt,
  output logic [1:0] M_fwd_rt
);

  logic [1:0] w_rs_tuse;
  logic [1:0] w_rt_tuse;
  logic [1:0] w_d_tnew;
  logic       w_rs_stall;
  logic       w_rt_stall;

  // Stage records
  logic [4:0] r_e_rs;
  logic [4:0] r_e_rt;
  logic [4:0] r_e_a3;
  logic [1:0] r_e_tnew;
  logic [1:0] r_e_rt_tuse;
  logic [4:0] r_m_rt;
  logic [4:0] r_m_a3;
  logic [1:0] r_m_tnew;
  logic [1:0] r_m_rt_tuse;
  logic [4:0] r_w_a3;

  function automatic logic [1:0] age(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  assign w_rs_tuse = D_rs_Tuse ? 2'd0 : (E_rs_Tuse ? 2'd1 : 2'd3);
  assign w_rt_tuse = D_rt_Tuse ? 2'd0 : (E_rt_Tuse ? 2'd1 : (M_rt_Tuse ? 2'd2 : 2'd3));
  assign w_d_tnew  = D_WDsel ? 2'd0 : (M_WDSel ? 2'd2 : ((E_WDSel == 2'b01) ? 2'd1 : 2'd0));

`ifdef HAZARD_FWD_EN
  // Nearest producer wins; a producer only forwards once its result exists (Tnew==0).
  function automatic logic [1:0] sel_d(input logic [4:0] r, input logic [4:0] e_a3,
                                       input logic [1:0] e_tnew, input logic [4:0] m_a3,
                                       input logic [1:0] m_tnew, input logic [4:0] w_a3);
    logic [1:0] s;
    s = 2'b00;
    if (r != 5'd0) begin
      if (r == e_a3 && e_tnew == 2'd0)      s = 2'b01;
      else if (r == m_a3 && m_tnew == 2'd0) s = 2'b10;
      else if (r == w_a3)                   s = 2'b11;
    end
    return s;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] r, input logic [4:0] m_a3,
                                       input logic [1:0] m_tnew, input logic [4:0] w_a3);
    logic [1:0] s;
    s = 2'b00;
    if (r != 5'd0) begin
      if (r == m_a3 && m_tnew == 2'd0) s = 2'b10;
      else if (r == w_a3)              s = 2'b11;
    end
    return s;
  endfunction

  assign w_rs_stall = (D_rs != 5'd0) &&
                      ((D_rs == r_e_a3 && w_rs_tuse < r_e_tnew) ||
                       (D_rs == r_m_a3 && w_rs_tuse < r_m_tnew));
  assign w_rt_stall = (D_rt != 5'd0) &&
                      ((D_rt == r_e_a3 && w_rt_tuse < r_e_tnew) ||
                       (D_rt == r_m_a3 && w_rt_tuse < r_m_tnew));

  assign D_fwd_rs = sel_d(D_rs, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew, r_w_a3);
  assign D_fwd_rt = sel_d(D_rt, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew, r_w_a3);
  assign E_fwd_rs = sel_e(r_e_rs, r_m_a3, r_m_tnew, r_w_a3);
  assign E_fwd_rt = sel_e(r_e_rt, r_m_a3, r_m_tnew, r_w_a3);
  assign M_fwd_rt = (r_m_rt != 5'd0 && r_m_rt == r_w_a3) ? 2'b11 : 2'b00;

  logic w_unused_bits;
  assign w_unused_bits = ^r_m_rt_tuse;
`else
  // GRF is not write-through, so a pending write in W must still block the reader.
  assign w_rs_stall = (D_rs != 5'd0) && (w_rs_tuse != 2'd3) &&
                      (D_rs == r_e_a3 || D_rs == r_m_a3 || D_rs == r_w_a3);
  assign w_rt_stall = (D_rt != 5'd0) && (w_rt_tuse != 2'd3) &&
                      (D_rt == r_e_a3 || D_rt == r_m_a3 || D_rt == r_w_a3);

  assign D_fwd_rs = 2'b00;
  assign D_fwd_rt = 2'b00;
  assign E_fwd_rs = 2'b00;
  assign E_fwd_rt = 2'b00;
  assign M_fwd_rt = 2'b00;

  logic w_unused_bits;
  assign w_unused_bits = ^{r_e_rs, r_m_rt, r_m_tnew, r_m_rt_tuse};
`endif

  assign stall = w_rs_stall | w_rt_stall;
  assign PC_en = ~stall;
  assign D_en  = ~stall;
  assign E_clr = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_rs      <= 5'd0;
      r_e_rt      <= 5'd0;
      r_e_a3      <= 5'd0;
      r_e_tnew    <= 2'd0;
      r_e_rt_tuse <= 2'd0;
      r_m_rt      <= 5'd0;
      r_m_a3      <= 5'd0;
      r_m_tnew    <= 2'd0;
      r_m_rt_tuse <= 2'd0;
      r_w_a3      <= 5'd0;
    end else begin
      if (stall) begin
        r_e_rs      <= 5'd0;
        r_e_rt      <= 5'd0;
        r_e_a3      <= 5'd0;
        r_e_tnew    <= 2'd0;
        r_e_rt_tuse <= 2'd0;
      end else begin
        r_e_rs      <= D_rs;
        r_e_rt      <= D_rt;
        r_e_a3      <= D_A3;
        r_e_tnew    <= w_d_tnew;
        r_e_rt_tuse <= w_rt_tuse;
      end
      r_m_rt      <= r_e_rt;
      r_m_a3      <= r_e_a3;
      r_m_tnew    <= age(r_e_tnew);
      r_m_rt_tuse <= r_e_rt_tuse;
      r_w_a3      <= r_m_a3;
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall and forwarding controller for the five-stage MIPS pipeline. It consumes the per-instruction decode outputs of the controller: destination register, result-source selects, and the rs/rt use-stage flags. It tracks each in-flight writer's destination and its remaining cycles-to-result (Tnew) through E, M and W, and from that produces the pipeline stall/flush enables and the D-, E- and M-stage forwarding mux selects. The datapath top instantiates it beside the controller and pipeline registers.

## Interface
- No parameters.
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high; clears all stage records
- D_rs  input  5  instr[25:21] of the D-stage instruction
- D_rt  input  5  instr[20:16] of the D-stage instruction
- D_A3  input  5  D-stage destination register (0 = no write)
- D_WDsel  input  1  jal/jalr (result = PC+8)
- E_WDSel  input  2  2'b01 = ALU result
- M_WDSel  input  1  load (result = DM read data)
- D_rs_Tuse, D_rt_Tuse  input  1 each  operand consumed in D (Tuse=0)
- E_rs_Tuse, E_rt_Tuse  input  1 each  operand consumed in E (Tuse=1)
- M_rt_Tuse  input  1  rt consumed in M (sw store data, Tuse=2)
- stall  output  1  freeze PC and F/D register
- PC_en, D_en  output  1 each  equal to ~stall
- E_clr  output  1  equal to stall; inserts a bubble into the D/E register
- D_fwd_rs, D_fwd_rt  output  2 each  00 GRF, 01 E (PC+8), 10 M, 11 W
- E_fwd_rs, E_fwd_rt  output  2 each  00 D/E register, 10 M, 11 W (01 unused)
- M_fwd_rt  output  2  00 E/M register, 11 W

## Operation
- Tuse per operand:
  - 0 if the D flag is set.
  - Otherwise 1 if the E flag is set.
  - Otherwise, for rt only, 2 if M_rt_Tuse is set.
  - Otherwise 3 (unused).
- D-stage Tnew, measured from E entry:
  - 0 if D_WDsel.
  - Otherwise 2 if M_WDSel.
  - Otherwise 1 if E_WDSel==2'b01.
  - Otherwise 0.
- Internal records (all registered):
  - E: {rs, rt, A3, Tnew[1:0], rt_Tuse[1:0]}.
  - M: {rt, A3, Tnew, rt_Tuse}.
  - W: {A3}.
- Stall condition. Stall when either operand (rs or rt) meets all of:
  - the operand register is nonzero;
  - it equals E.A3 with Tuse < E.Tnew, or equals M.A3 with Tuse < M.Tnew.
- Forwarding is asserted only when the matching record has A3 ≠ 0 and A3 equals the operand register. Priority is nearest stage first.
  - D_fwd: E (only if E.Tnew==0), else M (only if M.Tnew==0), else W, else 00.
  - E_fwd: M (only if M.Tnew==0), else W, else 00. Uses E.rs/E.rt.
  - M_fwd_rt: W if W.A3==M.rt, else 00.
- Register 0 never stalls and never forwards.

## Timing
- Stall, enables and forward selects are combinational from the current records and D-stage inputs; they are valid in the same cycle.
- Record update at each rising clk:
  - If reset: all records are zeroed.
  - Else if stall: E ← bubble (all zero); M ← aged E; W ← M.A3.
  - Else: E ← D-stage values; M ← aged E; W ← M.A3.
  - Aging: Tnew' = (Tnew==0) ? 0 : Tnew−1.
- Reset values: all records zero. Therefore stall=0, PC_en=D_en=1, E_clr=0 and all forward selects 00 regardless of inputs.
- Reset asserted mid-stall discards all in-flight records; the next cycle is stall-free.
- Stalls are bounded:
  - load → D use: 2 cycles.
  - load → E use: 1 cycle.
  - ALU → D use: 1 cycle.
  - Load → sw data (Tuse=2): never stalls; forwarded W→M.

## Configuration
- HAZARD_FWD_EN defined: behaviour as above.
- HAZARD_FWD_EN undefined:
  - All forward selects are tied to 00.
  - Stall whenever a used operand (Tuse<3, nonzero) equals E.A3, M.A3 or W.A3 (any nonzero A3), regardless of Tnew.
  - The GRF is written on the rising edge and is not write-through, so W matches must also stall.

## Test plan
- Reset for 2 cycles with arbitrary inputs (D_rs=D_A3=5) → stall=0, all forward selects 00.
- Issue `lw $8` (M_WDSel=1, D_A3=8), then `beq $8,$9` (D_rs=8, D_rs_Tuse=1).
  - Cycles 1–2: stall=1.
  - Cycle 3: stall=0, D_fwd_rs=11.
- Issue `lw $8`, then `addu $3,$8,$2` (E_rs_Tuse=1, D_rs=8).
  - Stall exactly 1 cycle.
  - Then with addu in E: E_fwd_rs=11.
- Issue `jal` (D_WDsel=1, D_A3=31), then `jr $31`.
  - No stall.
  - D_fwd_rs=01 while jal is in E.
- Issue `lw $5`, then `sw $5` (M_rt_Tuse=1, D_rt=5).
  - No stall.
  - When sw is in M: M_fwd_rt=11.
- Issue `addu $0,...`, then `beq $0,$0` → stall=0 and D_fwd_rs=D_fwd_rt=00.
- With HAZARD_FWD_EN undefined: `addu $4`, then `subu` using $4 in E → stall 3 cycles, all selects 00.
